// File: rtl/fix14_to_ulaw_conv.sv
// fix14_to_ulaw_conv
//   Two-stage pipelined G.711 mu-law compressor for 14-bit two's-complement
//   samples. It emits the transmitted (bit-inverted) 8-bit code.
//   Stage 1 takes the magnitude, clips it and adds the bias.
//   Stage 2 finds the segment and mantissa and forms the code.
//   Optional build macro: ULAW_ZERO_TRAP_EN. When it is defined, a final code
//   of 8'h00 is replaced by 8'h02 (zero-code suppression).
module fix14_to_ulaw_conv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [13:0] in,
    output logic        out_valid,
    output logic [7:0]  out
);

    localparam logic [13:0] CLIP = 14'd8158;
    localparam logic [12:0] BIAS = 13'd33;

    // Stage 1 combinational signals.
    logic [13:0] mag_full;
    logic [12:0] mag_clip;
    logic [11:0] b_half_next;   // biased magnitude with its LSB dropped (never used by stage 2)

    // Stage 1 registers.
    logic        v1_reg;
    logic        s_reg;
    logic [11:0] b_half_reg;    // holds b[12:1]

    // Stage 2 combinational signals.
    logic [2:0]  seg;
    logic [3:0]  mant_cand [8];
    logic [3:0]  mant;
    logic [7:0]  code_next;

    // Stage 2 registers.
    logic        out_valid_reg;
    logic [7:0]  out_reg;

    // Magnitude is 14 bits wide, so -8192 gives 8192 and is then clipped.
    always_comb begin
        mag_full    = in[13] ? (~in + 14'd1) : in;
        mag_clip    = (mag_full > CLIP) ? CLIP[12:0] : mag_full[12:0];
        b_half_next = 12'((mag_clip + BIAS) >> 1);
    end

    // Stage 1 pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg     <= 1'b0;
            s_reg      <= 1'b0;
            b_half_reg <= 12'd0;
        end else begin
            v1_reg     <= in_valid;
            s_reg      <= in[13];
            b_half_reg <= b_half_next;
        end
    end

    // Precompute the 4-bit mantissa window for each of the eight segments.
    // For segment gi the leading one is at b[gi+5], so the mantissa is b[gi+4:gi+1].
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mant
            assign mant_cand[gi] = b_half_reg[gi+3:gi];
        end
    endgenerate

    // The highest set bit among b[12:5] selects the segment. b >= 32 always holds.
    always_comb begin
        seg = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (b_half_reg[i+4]) begin
                seg = 3'(i);
            end
        end
        mant      = mant_cand[seg];
        code_next = ~{s_reg, seg, mant};
`ifdef ULAW_ZERO_TRAP_EN
        if (code_next == 8'h00) begin
            code_next = 8'h02;
        end
`endif
    end

    // Stage 2 output register. The code holds its last value across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_reg       <= 8'hFF;
        end else begin
            out_valid_reg <= v1_reg;
            if (v1_reg) begin
                out_reg <= code_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out       = out_reg;

endmodule

// File: tb/tb_fix14_to_ulaw_conv.sv
// tb_fix14_to_ulaw_conv
//   Randomly bubbled stream checked against an arithmetic G.711 reference model.
//   Also covers directed boundary codes, reset behaviour and a full 14-bit sweep.
//   Honours ULAW_ZERO_TRAP_EN the same way the design does.
module tb_fix14_to_ulaw_conv;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [13:0] in;
    logic        out_valid;
    logic [7:0]  out;

    int n_checks = 0;
    int n_fails  = 0;

    // Model of the two-cycle delay line: [0] was driven last cycle, [1] the cycle before.
    logic        hist_v [2];
    logic [13:0] hist_x [2];
    logic [7:0]  exp_hold;

`ifdef ULAW_ZERO_TRAP_EN
    localparam logic [7:0] ZCODE = 8'h02;
`else
    localparam logic [7:0] ZCODE = 8'h00;
`endif

    fix14_to_ulaw_conv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in        (in),
        .out_valid (out_valid),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    // C-style G.711 encoder. It searches segments by threshold and takes the
    // mantissa as the four bits below the leading one.
    function automatic logic [7:0] ulaw_ref(input logic [13:0] x);
        int v, mag, b, seg, mant, code;
        v   = int'($signed(x));
        mag = (v < 0) ? -v : v;
        if (mag > 8158) mag = 8158;
        b   = mag + 33;
        seg = 0;
        while (seg < 7 && b >= (64 << seg)) seg++;
        mant = (b >> (seg + 1)) & 15;
        code = ((v < 0) ? 128 : 0) | (seg << 4) | mant;
        code = (~code) & 255;
`ifdef ULAW_ZERO_TRAP_EN
        if (code == 0) code = 2;
`endif
        return code[7:0];
    endfunction

    task automatic clear_model();
        hist_v[0] = 1'b0; hist_v[1] = 1'b0;
        hist_x[0] = '0;   hist_x[1] = '0;
        exp_hold  = 8'hFF;
    endtask

    // One clock cycle: check outputs against the model, then drive the next input.
    task automatic cycle(input logic v, input logic [13:0] x);
        @(negedge clk);
        check("valid", {7'd0, out_valid}, {7'd0, hist_v[1]});
        if (hist_v[1]) exp_hold = ulaw_ref(hist_x[1]);
        check(hist_v[1] ? "code" : "hold", out, exp_hold);
        hist_v[1] = hist_v[0]; hist_x[1] = hist_x[0];
        hist_v[0] = v;         hist_x[0] = x;
        in_valid  = v;
        in        = x;
    endtask

    // A single isolated sample whose code is also compared to a fixed constant.
    task automatic directed(input string tag, input logic [13:0] x, input logic [7:0] exp);
        cycle(1'b1, x);
        cycle(1'b0, 14'd0);
        cycle(1'b0, 14'd0);
        check(tag, out, exp);
    endtask

    // Assert reset asynchronously between edges. Outputs must clear immediately.
    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_code", out, 8'hFF);
        check("rst_valid", {7'd0, out_valid}, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_model();
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in       = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check("init_code", out, 8'hFF);
        check("init_valid", {7'd0, out_valid}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        directed("zero",     14'd0,    8'hFF);
        directed("plus1",    14'd1,    8'hFE);
        directed("minus1",   14'h3FFF, 8'h7E);
        directed("p31",      14'd31,   8'hEF);
        directed("m8061",    14'b10000010000011, ZCODE);
        directed("p8188",    14'd8188, 8'h80);
        directed("p8191",    14'd8191, 8'h80);
        directed("m8192",    14'h2000, ZCODE);

        // Back-to-back stream with a mid-stream reset, then resume.
        for (int i = 0; i < 40; i++) cycle(1'b1, 14'($urandom));
        mid_reset();
        cycle(1'b1, 14'd100);
        cycle(1'b0, 14'd0);
        cycle(1'b0, 14'd0);   // out_valid must be high exactly here
        cycle(1'b0, 14'd0);

        // Full sweep of every input code, with random bubbles between samples.
        for (int i = 0; i < 16384; i++) begin
            if ($urandom_range(3) == 0) cycle(1'b0, 14'($urandom));
            cycle(1'b1, 14'(i));
        end
        cycle(1'b0, 14'd0);
        cycle(1'b0, 14'd0);
        cycle(1'b0, 14'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
